// File: rtl/instr_fetch_q.sv
// instr_fetch_q -- instruction beat parser feeding a small FIFO of decoded entries.
//
// The parser walks a stream of 6-bit beats. A sync beat (6'h3F) enters the
// instruction stream. After that, each instruction is one to three beats:
//   B1: {opcode, src_a}. Opcode 0 is a single-beat instruction.
//   B2: {dest, src_b} or {dest, imm[7:5]}. IMM_MASK[opcode] selects which form.
//   B3: imm[4:0]. Only immediate-carrying opcodes have this beat.
// A completed instruction is pushed as {opcode, src_a, src_b, dest, imm}.
// The parser then returns to B1, so a new sync is not needed between instructions.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous flush of parser and queue (highest priority)
//   in_valid   beat present on `in`
//   in         6-bit instruction beat
//   in_ready   beat accepted when in_valid=1 (queue not full)
//   out_valid  queue head valid
//   out_ready  consumer takes the head when out_valid=1
//   opcode/src_a/src_b/dest/imm  head-entry fields (zero when out_valid=0)
//   level      number of queued entries
module instr_fetch_q #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [7:0]  IMM_MASK = 8'b1101_0100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [5:0]               in,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               opcode,
  output logic [2:0]               src_a,
  output logic [2:0]               src_b,
  output logic [2:0]               dest,
  output logic [7:0]               imm,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned LW      = AW + 1;
  localparam int unsigned ENTRY_W = 20;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    B1   = 2'd1,
    B2   = 2'd2,
    B3   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          opcode_q, opcode_d;
  logic [2:0]          src_a_q, src_a_d;
  logic [2:0]          dest_q, dest_d;
  logic [2:0]          imm_hi_q, imm_hi_d;

  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic [ENTRY_W-1:0]  mem_q [DEPTH];

  logic                accept_s;
  logic                push_s;
  logic                pop_s;
  logic                out_valid_s;
  logic [ENTRY_W-1:0]  push_data_s;
  logic [ENTRY_W-1:0]  head_s;

  // Handshake qualifiers. Backpressure depends only on occupancy, never on out_ready.
  always_comb begin
    in_ready    = (level_q != DEPTH_L);
    out_valid_s = (level_q != {LW{1'b0}});
    accept_s    = in_valid & in_ready;
    pop_s       = out_valid_s & out_ready;
  end

  // Beat parser: next state, partial-instruction fields and the completed entry.
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    src_a_d     = src_a_q;
    dest_d      = dest_q;
    imm_hi_d    = imm_hi_q;
    push_s      = 1'b0;
    push_data_s = {ENTRY_W{1'b0}};
    if (accept_s) begin
      case (state_q)
        SYNC: begin
          if (in == 6'h3F) begin
            state_d = B1;
          end else begin
            state_d = SYNC;
          end
        end
        B1: begin
          opcode_d = in[5:3];
          src_a_d  = in[2:0];
          if (in[5:3] == 3'b000) begin
            // Single-beat instruction: complete immediately, stay ready for the next B1.
            push_s      = 1'b1;
            push_data_s = {in[5:3], in[2:0], 3'b000, 3'b000, 8'h00};
            state_d     = B1;
          end else begin
            state_d = B2;
          end
        end
        B2: begin
          dest_d = in[5:3];
          if (IMM_MASK[opcode_q]) begin
            imm_hi_d = in[2:0];
            state_d  = B3;
          end else begin
            push_s      = 1'b1;
            push_data_s = {opcode_q, src_a_q, in[2:0], in[5:3], 8'h00};
            state_d     = B1;
          end
        end
        B3: begin
          // in[5] carries no information in the low-immediate beat.
          push_s      = 1'b1;
          push_data_s = {opcode_q, src_a_q, 3'b000, dest_q, imm_hi_q, in[4:0]};
          state_d     = B1;
        end
        default: begin
          state_d = SYNC;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Queue pointer and occupancy update. Push cannot coincide with full because in_ready gates it.
  always_comb begin
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Parser and queue control state; flush outranks any push/pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SYNC;
      opcode_q <= 3'b000;
      src_a_q  <= 3'b000;
      dest_q   <= 3'b000;
      imm_hi_q <= 3'b000;
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else if (flush) begin
      state_q  <= SYNC;
      opcode_q <= 3'b000;
      src_a_q  <= 3'b000;
      dest_q   <= 3'b000;
      imm_hi_q <= 3'b000;
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      src_a_q  <= src_a_d;
      dest_q   <= dest_d;
      imm_hi_q <= imm_hi_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_q[wr_ptr_q] <= push_data_s;
    end
  end

  // Head presentation straight from storage, zeroed when the queue is empty.
  always_comb begin
    head_s    = mem_q[rd_ptr_q];
    out_valid = out_valid_s;
    level     = level_q;
    if (out_valid_s) begin
      opcode = head_s[19:17];
      src_a  = head_s[16:14];
      src_b  = head_s[13:11];
      dest   = head_s[10:8];
      imm    = head_s[7:0];
    end else begin
      opcode = 3'b000;
      src_a  = 3'b000;
      src_b  = 3'b000;
      dest   = 3'b000;
      imm    = 8'h00;
    end
  end

endmodule

// File: tb/tb_instr_fetch_q.sv
// Directed bench for instr_fetch_q (DEPTH=4, default IMM_MASK).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_instr_fetch_q;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [5:0] in;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] opcode, src_a, src_b, dest;
  logic [7:0] imm;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  instr_fetch_q #(.DEPTH(4), .IMM_MASK(8'b1101_0100)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in(in),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .src_a(src_a), .src_b(src_b), .dest(dest),
    .imm(imm), .level(level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [2:0] op,
                          input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] d, input logic [7:0] im);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".opcode"},    32'(opcode),    32'(op));
    chk({tag, ".src_a"},     32'(src_a),     32'(a));
    chk({tag, ".src_b"},     32'(src_b),     32'(b));
    chk({tag, ".dest"},      32'(dest),      32'(d));
    chk({tag, ".imm"},       32'(imm),       32'(im));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [5:0] b);
    in_valid = 1'b1;
    in       = b;
    step();
    in_valid = 1'b0;
    in       = 6'h00;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in        = 6'h00;
    out_ready = 1'b0;
    #1;
    chk_head("reset", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
    chk("reset.level", 32'(level), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;

    // Single-beat opcode 0 instruction.
    out_ready = 1'b1;
    beat(6'h3F);
    chk("t1.after_sync.level", 32'(level), 32'd0);
    beat(6'h05);
    chk_head("t1.head", 1'b1, 3'd0, 3'd5, 3'd0, 3'd0, 8'h00);
    chk("t1.level", 32'(level), 32'd1);
    step();
    chk_head("t1.popped", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
    chk("t1.popped.level", 32'(level), 32'd0);

    // Two-beat register form (opcode 1 has no immediate).
    out_ready = 1'b0;
    pulse_flush();
    beat(6'h3F);
    beat(6'h0B);
    chk("t2.mid.level", 32'(level), 32'd0);
    beat(6'h2A);
    chk_head("t2.head", 1'b1, 3'd1, 3'd3, 3'd2, 3'd5, 8'h00);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t2.popped.level", 32'(level), 32'd0);

    // Three-beat immediate form (opcode 2); parser already in B1.
    beat(6'h16);
    beat(6'h3D);
    chk("t3.mid.level", 32'(level), 32'd0);
    beat(6'h13);
    chk_head("t3.head", 1'b1, 3'd2, 3'd6, 3'd0, 3'd7, 8'hB3);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t3.popped.level", 32'(level), 32'd0);

    // Fill to DEPTH, hold the fifth beat, then drain.
    beat(6'h01);
    beat(6'h02);
    beat(6'h03);
    beat(6'h04);
    chk("t4.full.level", 32'(level), 32'd4);
    chk("t4.full.in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in       = 6'h05;
    step();
    chk("t4.held.level", 32'(level), 32'd4);
    chk("t4.held.src_a", 32'(src_a), 32'd1);
    step();
    chk("t4.held2.level", 32'(level), 32'd4);
    out_ready = 1'b1;
    step();
    chk("t4.pop1.level", 32'(level), 32'd3);
    chk("t4.pop1.in_ready", 32'(in_ready), 32'd1);
    chk("t4.pop1.src_a", 32'(src_a), 32'd2);
    step();
    in_valid = 1'b0;
    in       = 6'h00;
    chk("t4.pushpop.level", 32'(level), 32'd3);
    chk("t4.pushpop.src_a", 32'(src_a), 32'd3);
    step();
    chk("t4.d1.src_a", 32'(src_a), 32'd4);
    chk("t4.d1.level", 32'(level), 32'd2);
    step();
    chk("t4.d2.src_a", 32'(src_a), 32'd5);
    chk("t4.d2.level", 32'(level), 32'd1);
    step();
    chk_head("t4.empty", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
    out_ready = 1'b0;

    // Sustained push+pop at level 2 across pointer wrap.
    beat(6'h06);
    beat(6'h07);
    chk("t5.level", 32'(level), 32'd2);
    chk("t5.head0", 32'(src_a), 32'd6);
    out_ready = 1'b1;
    beat(6'h01);
    chk("t5.s1.level", 32'(level), 32'd2);
    chk("t5.s1.src_a", 32'(src_a), 32'd7);
    beat(6'h02);
    chk("t5.s2.level", 32'(level), 32'd2);
    chk("t5.s2.src_a", 32'(src_a), 32'd1);
    beat(6'h03);
    chk("t5.s3.level", 32'(level), 32'd2);
    chk("t5.s3.src_a", 32'(src_a), 32'd2);
    beat(6'h04);
    chk("t5.s4.level", 32'(level), 32'd2);
    chk("t5.s4.src_a", 32'(src_a), 32'd3);
    step();
    chk("t5.d1.src_a", 32'(src_a), 32'd4);
    chk("t5.d1.level", 32'(level), 32'd1);
    step();
    chk("t5.d2.level", 32'(level), 32'd0);
    out_ready = 1'b0;

    // Flush while in B3 with three entries queued.
    beat(6'h01);
    beat(6'h02);
    beat(6'h03);
    beat(6'h16);
    beat(6'h3D);
    chk("t6.pre.level", 32'(level), 32'd3);
    pulse_flush();
    chk_head("t6.flushed", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
    chk("t6.flushed.level", 32'(level), 32'd0);
    chk("t6.flushed.in_ready", 32'(in_ready), 32'd1);
    beat(6'h13);
    chk("t6.discard13.level", 32'(level), 32'd0);
    beat(6'h05);
    chk("t6.discard05.level", 32'(level), 32'd0);
    beat(6'h3F);
    beat(6'h05);
    chk_head("t6.resync", 1'b1, 3'd0, 3'd5, 3'd0, 3'd0, 8'h00);

    // Flush beats a simultaneous push and pop.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in        = 6'h02;
    flush     = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t6b.level", 32'(level), 32'd0);
    chk("t6b.out_valid", 32'(out_valid), 32'd0);
    beat(6'h02);
    chk("t6b.sync_needed.level", 32'(level), 32'd0);
    out_ready = 1'b0;

    // Asynchronous reset while in B3 with three entries queued.
    beat(6'h3F);
    beat(6'h01);
    beat(6'h02);
    beat(6'h03);
    beat(6'h16);
    beat(6'h3D);
    chk("t7.pre.level", 32'(level), 32'd3);
    rst = 1'b1;
    #1;
    chk_head("t7.rst", 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
    chk("t7.rst.level", 32'(level), 32'd0);
    chk("t7.rst.in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    beat(6'h13);
    chk("t7.discard13.level", 32'(level), 32'd0);
    // After sync: 13 -> op2 a3, 2A -> d5 imm[7:5]=2, 3F in B3 -> imm[4:0]=1F.
    beat(6'h3F);
    beat(6'h13);
    beat(6'h2A);
    chk("t7.mid.level", 32'(level), 32'd0);
    beat(6'h3F);
    chk_head("t7.imm_entry", 1'b1, 3'd2, 3'd3, 3'd0, 3'd5, 8'h5F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_q.md
INSTR_FETCH_Q -- requirements
Module: instr_fetch_q

Interface
REQ-001 Parameter DEPTH, default 4, instruction queue depth in entries; power of two, minimum 2.
REQ-002 Parameter IMM_MASK, default 8'b1101_0100, bit k=1 means opcode k carries an 8-bit immediate.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  synchronous flush of the parser and the queue.
REQ-006 in_valid  input  1  the input beat is present.
REQ-007 in  input  6  instruction beat.
REQ-008 in_ready  output  1  the beat is accepted this cycle when in_valid=1.
REQ-009 out_valid  output  1  the queue head is valid.
REQ-010 out_ready  input  1  the consumer takes the head this cycle when out_valid=1.
REQ-011 opcode, src_a, src_b, dest  output  3 each  head-entry fields.
REQ-012 imm  output  8  head-entry immediate.
REQ-013 level  output  clog2(DEPTH)+1  number of queued entries.

Function
REQ-014 A beat is consumed only when in_valid=1 and in_ready=1; the parser ignores all other cycles and holds its state.
REQ-015 in_ready SHALL equal (level != DEPTH) and SHALL not depend on out_ready; when the queue is full, all beats stall, including sync and non-final beats.
REQ-016 Parser states: SYNC, B1, B2, B3; reset and flush state = SYNC.
REQ-017 SYNC: an accepted beat of 6'b111111 moves to B1; any other accepted beat is discarded and the state stays SYNC.
REQ-018 B1: the accepted beat latches opcode=in[5:3] and src_a=in[2:0].
REQ-019 B1: if in[5:3]==000, the instruction completes with src_b=0, dest=0, imm=0, and the state stays B1; otherwise the state goes to B2.
REQ-020 B2: the accepted beat latches dest=in[5:3].
REQ-021 B2: if IMM_MASK[opcode]=1, it latches imm[7:5]=in[2:0] and goes to B3.
REQ-022 B2: if IMM_MASK[opcode]=0, it latches src_b=in[2:0], sets imm=0, completes the instruction and goes to B1.
REQ-023 B3: the accepted beat latches imm[4:0]=in[4:0], sets src_b=0, completes the instruction and goes to B1; in[5] is ignored.
REQ-024 Completion pushes {opcode,src_a,src_b,dest,imm} into the queue on the same edge that accepts the final beat; out_valid/level reflect it from the following cycle (1-cycle latency to an empty queue's head).
REQ-025 Queue is FIFO order; the head is presented combinationally from storage, and fields are 0 when out_valid=0.
REQ-026 A pop occurs when out_valid=1 and out_ready=1; the head advances at the edge.
REQ-027 Simultaneous push and pop SHALL leave level unchanged and keep ordering.
REQ-028 Pointers wrap modulo DEPTH; level never exceeds DEPTH and never underflows.
REQ-029 flush=1 for one cycle SHALL empty the queue (level=0, out_valid=0) and return the parser to SYNC at that edge.
REQ-030 A flush SHALL discard any partial instruction and any push/pop in that cycle; flush has priority over all other events.

Reset
REQ-031 rst=1 SHALL immediately force parser=SYNC, level=0, out_valid=0, in_ready=1, head fields=0, and all queue pointers to 0.
REQ-032 A reset mid-instruction SHALL discard the partial instruction; after release, a new sync beat is required.
REQ-033 Queue storage contents need not be reset.

Verification
REQ-034 Reset, then beats 3F, 05 with out_ready=1 -> one cycle after the 05 beat, out_valid=1, opcode=0, src_a=5, src_b=0, dest=0, imm=0.
REQ-035 Sync, then beats 0B (op1,a3), 2A (d5,b2) -> entry opcode=1, src_a=3, dest=5, src_b=2, imm=0.
REQ-036 Sync, then beats 16 (op2,a6), 3D (d7,imm[7:5]=5), 13 -> entry opcode=2, src_a=6, dest=7, imm=8'hB3, src_b=0.
REQ-037 DEPTH=4, out_ready=0, five single-beat instructions -> level=4, in_ready=0, fifth beat held; raise out_ready -> entries emerge in order, fifth accepted once a slot frees.
REQ-038 Queue at level 2, sustained push+pop each cycle -> level stays 2 and the output order matches the input order across pointer wrap.
REQ-039 Assert flush, or rst, in B3 with level=3 -> level=0, out_valid=0; a following 13 beat is discarded until a 3F sync beat is seen.
